seq_stage_ctrl: RTL and testbench

//  Multi-cycle sequencer for the Y86-64 SEQ core: holds the PC and steps fetch/decode/execute/memory/writeback/PC-update.

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/seq_next_pc.sv | 26 ++
 rtl/seq_stage_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ sequencer: instruction codes, status codes,
// sequencer state encoding and the memory-stage classification helper.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_t;

  // stage_en bit order is {pcupd, wb, mem, exe, dec, fetch}
  localparam logic [5:0] EN_FETCH = 6'b000001;
  localparam logic [5:0] EN_DEC   = 6'b000010;
  localparam logic [5:0] EN_EXE   = 6'b000100;
  localparam logic [5:0] EN_MEM   = 6'b001000;
  localparam logic [5:0] EN_WB    = 6'b010000;
  localparam logic [5:0] EN_PCUPD = 6'b100000;

  function automatic logic needs_mem(input logic [3:0] code);
    return (code == I_RMMOVQ) || (code == I_MRMOVQ) || (code == I_CALL) ||
           (code == I_RET)    || (code == I_PUSHQ)  || (code == I_POPQ);
  endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC selection for the PC-update stage; all inputs are the
// values latched by the sequencer during the current instruction.
module seq_next_pc
  import y86_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [3:0]      icode,
  input  logic            cnd,
  input  logic [PC_W-1:0] valp,
  input  logic [PC_W-1:0] valc,
  input  logic [PC_W-1:0] valm,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = valp;
    case (icode)
      I_CALL:  next_pc = valc;
      I_JXX:   next_pc = cnd ? valc : valp;
      I_RET:   next_pc = valm;
      default: next_pc = valp;
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ core: owns the PC, walks the six
// stages one per cycle, handshakes data memory and tracks the status code.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int              PC_W        = 64,
  parameter int              IMEM_SIZE   = 4096,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic [PC_W-1:0]  valP,
  input  logic [PC_W-1:0]  valC,
  input  logic             cnd,
  input  logic [PC_W-1:0]  valM,
  input  logic             dmem_done,
  input  logic             dmem_error,
  output logic [PC_W-1:0]  pc,
  output logic [5:0]       stage_en,
  output logic             dmem_req,
  output logic             wb_en,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output state_t           state_dbg
);

  localparam int              TO_W       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [PC_W-1:0] IMEM_LIMIT = PC_W'(IMEM_SIZE);

  state_t          state;
  logic [3:0]      icode_q;
  logic [PC_W-1:0] valp_q, valc_q, valm_q;
  logic            cnd_q;
  logic [TO_W-1:0] mem_cnt;
  logic [2:0]      dec_stat;
  logic [PC_W-1:0] next_pc;

  seq_next_pc #(.PC_W(PC_W)) u_next_pc (
    .icode   (icode_q),
    .cnd     (cnd_q),
    .valp    (valp_q),
    .valc    (valc_q),
    .valm    (valm_q),
    .next_pc (next_pc)
  );

  // Fetch fault priority: address error, then invalid instruction, then halt.
  always_comb begin
    dec_stat = STAT_AOK;
    if (imem_error)             dec_stat = STAT_ADR;
    else if (!instr_valid)      dec_stat = STAT_INS;
    else if (icode == I_HALT)   dec_stat = STAT_HLT;
  end

  // Memory handshake: dmem_req rises on entry to MEMORY and stays high until the
  // cycle in which dmem_done (a one-cycle pulse) is seen or the timeout expires;
  // dmem_error is meaningful only with dmem_done, and dmem_done outside MEMORY is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      stage_en  <= '0;
      dmem_req  <= 1'b0;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
      instr_cnt <= '0;
      icode_q   <= '0;
      valp_q    <= '0;
      valc_q    <= '0;
      valm_q    <= '0;
      cnd_q     <= 1'b0;
      mem_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && run) begin
            if (pc >= IMEM_LIMIT) begin
              stat   <= STAT_ADR;
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              stage_en <= EN_FETCH;
              state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          stage_en <= EN_DEC;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          icode_q <= icode;
          valp_q  <= valP;
          valc_q  <= valC;
          if (dec_stat != STAT_AOK) begin
            stat     <= dec_stat;
            halted   <= 1'b1;
            stage_en <= '0;
            state    <= S_HALTED;
          end else begin
            stage_en <= EN_EXE;
            state    <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          cnd_q <= cnd;
          if (needs_mem(icode_q)) begin
            stage_en <= EN_MEM;
            dmem_req <= 1'b1;
            mem_cnt  <= '0;
            state    <= S_MEMORY;
          end else begin
            stage_en <= EN_WB;
            state    <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (dmem_done) begin
            dmem_req <= 1'b0;
            if (dmem_error) begin
              stat     <= STAT_ADR;
              halted   <= 1'b1;
              stage_en <= '0;
              state    <= S_HALTED;
            end else begin
              valm_q   <= valM;
              stage_en <= EN_WB;
              state    <= S_WRITEBACK;
            end
          end else if (mem_cnt == TO_LAST) begin
            dmem_req <= 1'b0;
            stat     <= STAT_ADR;
            halted   <= 1'b1;
            stage_en <= '0;
            state    <= S_HALTED;
          end else begin
            mem_cnt <= mem_cnt + 1'b1;
          end
        end
        S_WRITEBACK: begin
          stage_en <= EN_PCUPD;
          state    <= S_PCUPD;
        end
        S_PCUPD: begin
          pc <= next_pc;
          if (instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
          if (run) begin
            stage_en <= EN_FETCH;
            state    <= S_FETCH;
          end else begin
            stage_en <= '0;
            state    <= S_IDLE;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          stage_en <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state != S_IDLE && state != S_HALTED && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign wb_en     = stage_en[4] && (stat == STAT_AOK);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed and randomized checks of seq_stage_ctrl against an instruction-level
// reference model (per-instruction cycle count, next PC, status, counters).
module tb_seq_stage_ctrl;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  localparam int         TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n, start, run;
  logic [3:0]  icode;
  logic        instr_valid, imem_error, cnd, dmem_done, dmem_error;
  logic [63:0] valP, valC, valM, pc;
  logic [5:0]  stage_en;
  logic        dmem_req, wb_en, halted;
  logic [2:0]  stat;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [2:0]  state_dbg;

  seq_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run(run),
    .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .valP(valP), .valC(valC), .cnd(cnd), .valM(valM),
    .dmem_done(dmem_done), .dmem_error(dmem_error),
    .pc(pc), .stage_en(stage_en), .dmem_req(dmem_req), .wb_en(wb_en),
    .stat(stat), .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus knobs for the next instruction
  logic [3:0]  t_ic;
  logic [63:0] t_vp, t_vc, t_vm;
  logic        t_cnd, t_iv, t_ie, t_de, t_spur, t_run_drop;
  int          t_lat;

  // reference model state
  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  logic [31:0] m_icnt, m_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [3:0] ic, input logic [63:0] vp, input logic [63:0] vc,
                           input logic c, input logic [63:0] vm, input int lat);
    t_ic = ic; t_vp = vp; t_vc = vc; t_cnd = c; t_vm = vm; t_lat = lat;
    t_iv = 1'b1; t_ie = 1'b0; t_de = 1'b0; t_spur = 1'b0; t_run_drop = 1'b0;
  endtask

  task automatic drive_fetch();
    icode = t_ic; valP = t_vp; valC = t_vc; cnd = t_cnd; valM = t_vm;
    instr_valid = t_iv; imem_error = t_ie;
  endtask

  function automatic logic is_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic [63:0] ref_next_pc();
    if (t_ic == 4'h8) return t_vc;
    if (t_ic == 4'h7 && t_cnd) return t_vc;
    if (t_ic == 4'h9) return t_vm;
    return t_vp;
  endfunction

  // Instruction-level model: cycles spent, memory cycles, status and next PC.
  task automatic model_instr(output int e_edges, output int e_memc, output logic e_wb);
    e_memc = 0;
    e_wb   = 1'b0;
    if (t_ie) begin
      m_stat = ADR; e_edges = 2;
    end else if (!t_iv) begin
      m_stat = INS; e_edges = 2;
    end else if (t_ic == 4'h0) begin
      m_stat = HLT; e_edges = 2;
    end else begin
      e_edges = 5;
      if (is_mem(t_ic)) begin
        if (t_lat < 1 || t_lat > TMO) begin
          e_memc = TMO; m_stat = ADR; e_edges = 3 + TMO;
        end else if (t_de) begin
          e_memc = t_lat; m_stat = ADR; e_edges = 3 + t_lat;
        end else begin
          e_memc = t_lat; e_edges = 5 + t_lat;
        end
      end
      if (m_stat == AOK) begin
        e_wb   = 1'b1;
        m_icnt = m_icnt + 1;
        m_pc   = ref_next_pc();
      end
    end
    m_cyc = m_cyc + 32'(e_edges);
  endtask

  // Called at a sample point where the DUT sits in FETCH; runs one instruction.
  task automatic exec_instr(input string tag);
    int          edges, memc, e_edges, e_memc;
    logic        wb_seen, fin, e_wb;
    logic [31:0] prev_icnt;
    drive_fetch();
    prev_icnt = instr_cnt;
    edges = 0; memc = 0; wb_seen = 1'b0; fin = 1'b0;
    do begin
      dmem_done = 1'b0; dmem_error = 1'b0;
      if (dmem_req) begin
        memc++;
        if (memc == t_lat) begin dmem_done = 1'b1; dmem_error = t_de; end
      end else if (t_spur) begin
        dmem_done = 1'b1; dmem_error = 1'b1;
      end
      @(posedge clk); #1;
      edges++;
      if (wb_en) wb_seen = 1'b1;
      if (t_run_drop && stage_en == 6'd4) run = 1'b0;
      if (instr_cnt != prev_icnt || halted) fin = 1'b1;
    end while (!fin && edges < 60);
    dmem_done = 1'b0; dmem_error = 1'b0;
    model_instr(e_edges, e_memc, e_wb);
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_cycles"}, edges, e_edges);
    chk({tag, "_memcyc"}, memc, e_memc);
    chk({tag, "_wb_en"}, wb_seen, e_wb);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_stat"}, stat, m_stat);
    chk({tag, "_halted"}, halted, m_stat != AOK);
    chk({tag, "_instr_cnt"}, instr_cnt, m_icnt);
    chk({tag, "_cycle_cnt"}, cycle_cnt, m_cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; run = 1'b0;
    icode = '0; instr_valid = 1'b0; imem_error = 1'b0; cnd = 1'b0;
    valP = '0; valC = '0; valM = '0; dmem_done = 1'b0; dmem_error = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_pc = '0; m_stat = AOK; m_icnt = '0; m_cyc = '0;
  endtask

  task automatic start_run();
    start = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  walk [4];
    logic [31:0] cyc_hold;
    int          k;
    logic [3:0]  ic_pool [11];
    walk    = '{6'd2, 6'd4, 6'd16, 6'd32};
    ic_pool = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

    // reset values
    do_reset();
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_stat", stat, AOK);
    chk("rst_halted", halted, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
    chk("rst_wb_en", wb_en, 0);

    // irmovq at 0: stage walk and retirement
    set_instr(4'h3, 64'd10, 64'h0, 1'b0, 64'h0, 0);
    drive_fetch();
    start_run();
    chk("walk_fetch", stage_en, 6'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("walk_stage", stage_en, walk[i]);
    end
    @(posedge clk); #1;
    chk("irmov_pc", pc, 64'd10);
    chk("irmov_instr_cnt", instr_cnt, 1);
    chk("irmov_cycle_cnt", cycle_cnt, 5);
    chk("irmov_refetch", stage_en, 6'd1);
    m_pc = 64'd10; m_icnt = 1; m_cyc = 5;

    // branches
    set_instr(4'h7, 64'h13, 64'h20, 1'b1, 64'h0, 0);   exec_instr("jmp20");
    set_instr(4'h7, 64'h29, 64'h100, 1'b1, 64'h0, 0);  exec_instr("jxx_taken");
    set_instr(4'h7, 64'h109, 64'h20, 1'b1, 64'h0, 0);  exec_instr("jmp20b");
    set_instr(4'h7, 64'h29, 64'h100, 1'b0, 64'h0, 0);  exec_instr("jxx_not_taken");

    // call / ret with memory latency
    set_instr(4'h8, 64'h32, 64'h40, 1'b0, 64'h0, 2);   exec_instr("call");
    set_instr(4'h9, 64'h41, 64'h0, 1'b0, 64'h29, 3);   exec_instr("ret");

    // done on the last cycle before timeout still completes
    set_instr(4'h5, 64'h33, 64'h0, 1'b0, 64'h0, TMO);  exec_instr("mem_lat_max");

    // randomized instruction stream
    for (int n = 0; n < 30; n++) begin
      set_instr(ic_pool[$urandom_range(0, 10)], m_pc + 64'($urandom_range(1, 10)),
                64'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                64'($urandom_range(0, 4095)), $urandom_range(1, 4));
      t_spur = 1'($urandom_range(0, 1));
      exec_instr("rand");
    end

    // run dropped in EXECUTE: instruction retires, then IDLE
    set_instr(4'h6, m_pc + 64'd2, 64'h0, 1'b0, 64'h0, 0);
    t_run_drop = 1'b1;
    exec_instr("run_drop");
    chk("run_drop_idle", stage_en, 0);
    cyc_hold = cycle_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_cycle_frozen", cycle_cnt, cyc_hold);
    chk("idle_pc", pc, m_pc);
    start_run();
    chk("resume_fetch", stage_en, 6'd1);

    // halt at 0x50
    set_instr(4'h7, 64'h0, 64'h50, 1'b1, 64'h0, 0);    exec_instr("jmp50");
    set_instr(4'h0, 64'h51, 64'h0, 1'b0, 64'h0, 0);    exec_instr("halt");
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; run = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("halted_stage_en", stage_en, 0);
    end
    chk("halted_pc", pc, 64'h50);
    chk("halted_stat", stat, HLT);
    chk("halted_flag", halted, 1);
    chk("halted_cycle_cnt", cycle_cnt, m_cyc);

    // invalid instruction
    do_reset();
    start_run();
    set_instr(4'h1, 64'h1, 64'h0, 1'b0, 64'h0, 0);
    t_iv = 1'b0;
    exec_instr("ins");

    // fetch address error
    do_reset();
    start_run();
    set_instr(4'h3, 64'hA, 64'h0, 1'b0, 64'h0, 0);
    t_ie = 1'b1;
    exec_instr("imem_err");

    // memory never answers
    do_reset();
    start_run();
    set_instr(4'h8, 64'h9, 64'h40, 1'b0, 64'h0, 0);
    exec_instr("mem_timeout");

    // memory error
    do_reset();
    start_run();
    set_instr(4'hA, 64'h2, 64'h0, 1'b0, 64'h0, 2);
    t_de = 1'b1;
    exec_instr("mem_err");

    // start from an out-of-range pc: ADR without fetching
    do_reset();
    start_run();
    set_instr(4'h7, 64'h9, 64'h1000, 1'b1, 64'h0, 0);
    t_run_drop = 1'b1;
    exec_instr("jmp_oob");
    cyc_hold = cycle_cnt;
    start_run();
    chk("oob_stage_en", stage_en, 0);
    chk("oob_stat", stat, ADR);
    chk("oob_halted", halted, 1);
    chk("oob_pc", pc, 64'h1000);
    chk("oob_cycle_cnt", cycle_cnt, cyc_hold);

    // asynchronous reset while the memory request is outstanding
    do_reset();
    start_run();
    set_instr(4'h7, 64'h9, 64'h80, 1'b1, 64'h0, 0);    exec_instr("jmp80");
    set_instr(4'h8, 64'h89, 64'h40, 1'b0, 64'h0, 0);
    drive_fetch();
    k = 0;
    while (!dmem_req && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mem_req_seen", dmem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", dmem_req, 0);
    chk("arst_pc", pc, 0);
    chk("arst_stage_en", stage_en, 0);
    chk("arst_instr_cnt", instr_cnt, 0);
    chk("arst_cycle_cnt", cycle_cnt, 0);
    @(negedge clk) rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
